// File: rtl/sram_sp_param.sv
// Parametrised single-port synchronous SRAM model: zero-init sequencer after reset,
// read latency 1 or 2 with valid strobe. Define SRAM_SP_PARITY_EN for per-lane parity.
module sram_sp_param #(
  parameter int DEPTH     = 4096,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int READ_LAT  = 1
) (
  input  logic                                CE1,
  input  logic                                RST1,
  input  logic                                CSB1,
  input  logic                                WEB1,
  input  logic [ADDR_W-1:0]                   A1,
  input  logic [WIDTH-1:0]                    I1,
  input  logic [((MASK_GRAN > 0) ? (WIDTH / MASK_GRAN) : 1)-1:0] WBM1,
  output logic [WIDTH-1:0]                    O1,
  output logic                                OV1,
  output logic                                BUSY1
`ifdef SRAM_SP_PARITY_EN
  ,
  input  logic                                INJ1,
  output logic                                PERR1
`endif
);

  localparam int LANES = (MASK_GRAN > 0) ? (WIDTH / MASK_GRAN) : 1;
`ifdef SRAM_SP_PARITY_EN
  localparam int LANE_W = MASK_GRAN + 1;
`else
  localparam int LANE_W = MASK_GRAN;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  generate
    if ((DEPTH < 2) || (WIDTH < 1) || (MASK_GRAN < 1) || ((WIDTH % MASK_GRAN) != 0) ||
        ((READ_LAT != 1) && (READ_LAT != 2)) || (ADDR_W < $clog2(DEPTH))) begin : g_bad_param
      $error("sram_sp_param: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  typedef logic [LANES-1:0][LANE_W-1:0] word_t;

`ifdef SRAM_SP_PARITY_EN
  function automatic logic even_par(input logic [MASK_GRAN-1:0] d);
    return ^d;
  endfunction

  // A stored lane (data plus parity bit) is consistent when its XOR is zero.
  function automatic logic lane_bad(input logic [LANE_W-1:0] l);
    return ^l;
  endfunction
`endif

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_s;
  logic                busy_r, busy_s;
  logic                init_we_s;
  logic                in_range_s;
  logic                wr_s;
  logic                rd_s;
  word_t               mem_r [DEPTH];
  word_t               rd_word_s;
  logic [WIDTH-1:0]    rd_data_s;
  logic                res_v_s;
  logic [WIDTH-1:0]    res_d_s;
  logic [WIDTH-1:0]    o1_r;
  logic                ov1_r;
`ifdef SRAM_SP_PARITY_EN
  logic                rd_perr_s;
  logic                res_p_s;
  logic                perr1_r;
`endif

  // FSM state, init counter and busy flag
  always_ff @(posedge CE1) begin
    if (RST1) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state logic and init-write strobe (no memory write on a reset edge)
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    busy_s    = busy_r;
    init_we_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        init_we_s = ~RST1;
        if (cnt_r == LAST_ADDR) begin
          state_s = ST_READY;
          busy_s  = 1'b0;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + ADDR_W'(1);
        end
      end
      ST_READY: begin
        busy_s = 1'b0;
      end
      default: begin
        state_s = ST_INIT;
        cnt_s   = '0;
        busy_s  = 1'b1;
      end
    endcase
  end

  assign in_range_s = ({1'b0, A1} < DEPTH_EXT);
  assign wr_s = (state_r == ST_READY) & ~RST1 & ~CSB1 & ~WEB1 & in_range_s;
  assign rd_s = (state_r == ST_READY) & ~RST1 & ~CSB1 & WEB1;

  // Memory array: init sequencer zeroes one word per cycle, user writes are lane-masked
  always_ff @(posedge CE1) begin
    if (init_we_s) begin
      mem_r[cnt_r] <= '0;
    end else if (wr_s) begin
      for (int k = 0; k < LANES; k++) begin
        if (WBM1[k]) begin
`ifdef SRAM_SP_PARITY_EN
          mem_r[A1][k] <= {even_par(I1[k*MASK_GRAN +: MASK_GRAN]) ^ INJ1,
                           I1[k*MASK_GRAN +: MASK_GRAN]};
`else
          mem_r[A1][k] <= I1[k*MASK_GRAN +: MASK_GRAN];
`endif
        end
      end
    end
  end

  // Read word lookup; out-of-range addresses read as zero
  always_comb begin
    rd_data_s = '0;
`ifdef SRAM_SP_PARITY_EN
    rd_perr_s = 1'b0;
`endif
    if (in_range_s) begin
      rd_word_s = mem_r[A1];
    end else begin
      rd_word_s = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      rd_data_s[k*MASK_GRAN +: MASK_GRAN] = rd_word_s[k][MASK_GRAN-1:0];
`ifdef SRAM_SP_PARITY_EN
      rd_perr_s = rd_perr_s | lane_bad(rd_word_s[k]);
`endif
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic             st_v_r;
      logic [WIDTH-1:0] st_d_r;
`ifdef SRAM_SP_PARITY_EN
      logic             st_p_r;
`endif
      // Extra read stage; cleared on reset so in-flight reads are dropped
      always_ff @(posedge CE1) begin
        if (RST1) begin
          st_v_r <= 1'b0;
          st_d_r <= '0;
`ifdef SRAM_SP_PARITY_EN
          st_p_r <= 1'b0;
`endif
        end else begin
          st_v_r <= rd_s;
          st_d_r <= rd_data_s;
`ifdef SRAM_SP_PARITY_EN
          st_p_r <= rd_perr_s;
`endif
        end
      end
      assign res_v_s = st_v_r;
      assign res_d_s = st_d_r;
`ifdef SRAM_SP_PARITY_EN
      assign res_p_s = st_p_r;
`endif
    end else begin : g_lat1
      assign res_v_s = rd_s;
      assign res_d_s = rd_data_s;
`ifdef SRAM_SP_PARITY_EN
      assign res_p_s = rd_perr_s;
`endif
    end
  endgenerate

  // Output register: data only loads on a valid result, otherwise holds
  always_ff @(posedge CE1) begin
    if (RST1) begin
      o1_r    <= '0;
      ov1_r   <= 1'b0;
`ifdef SRAM_SP_PARITY_EN
      perr1_r <= 1'b0;
`endif
    end else begin
      ov1_r <= res_v_s;
      if (res_v_s) begin
        o1_r <= res_d_s;
      end
`ifdef SRAM_SP_PARITY_EN
      perr1_r <= res_v_s & res_p_s;
`endif
    end
  end

  assign O1    = o1_r;
  assign OV1   = ov1_r;
  assign BUSY1 = busy_r;
`ifdef SRAM_SP_PARITY_EN
  assign PERR1 = perr1_r;
`endif

endmodule

// File: tb/tb_sram_sp_param.sv
// Directed bench for sram_sp_param: three instances (16/lat1, 16/lat2, 12/lat1) share one
// stimulus bus; parity checks are compiled in when SRAM_SP_PARITY_EN is defined.
module tb_sram_sp_param;

  logic        clk;
  logic        rst;
  logic        csb;
  logic        web;
  logic [3:0]  addr;
  logic [63:0] din;
  logic [7:0]  wbm;
  logic        inj;

  logic [63:0] o_a, o_b, o_c;
  logic        ov_a, ov_b, ov_c;
  logic        busy_a, busy_b, busy_c;
  logic        perr_a, perr_b, perr_c;

  int checks   = 0;
  int failures = 0;
  int cnt_a, cnt_b, cnt_c, ov_cnt;

  sram_sp_param #(.DEPTH(16), .WIDTH(64), .MASK_GRAN(8), .READ_LAT(1)) u_a (
    .CE1(clk), .RST1(rst), .CSB1(csb), .WEB1(web), .A1(addr), .I1(din), .WBM1(wbm),
    .O1(o_a), .OV1(ov_a), .BUSY1(busy_a)
`ifdef SRAM_SP_PARITY_EN
    , .INJ1(inj), .PERR1(perr_a)
`endif
  );

  sram_sp_param #(.DEPTH(16), .WIDTH(64), .MASK_GRAN(8), .READ_LAT(2)) u_b (
    .CE1(clk), .RST1(rst), .CSB1(csb), .WEB1(web), .A1(addr), .I1(din), .WBM1(wbm),
    .O1(o_b), .OV1(ov_b), .BUSY1(busy_b)
`ifdef SRAM_SP_PARITY_EN
    , .INJ1(inj), .PERR1(perr_b)
`endif
  );

  sram_sp_param #(.DEPTH(12), .WIDTH(64), .MASK_GRAN(8), .READ_LAT(1)) u_c (
    .CE1(clk), .RST1(rst), .CSB1(csb), .WEB1(web), .A1(addr), .I1(din), .WBM1(wbm),
    .O1(o_c), .OV1(ov_c), .BUSY1(busy_c)
`ifdef SRAM_SP_PARITY_EN
    , .INJ1(inj), .PERR1(perr_c)
`endif
  );

`ifndef SRAM_SP_PARITY_EN
  assign perr_a = 1'b0;
  assign perr_b = 1'b0;
  assign perr_c = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [63:0] d, input logic [7:0] m);
    csb  = 1'b0;
    web  = 1'b0;
    addr = a;
    din  = d;
    wbm  = m;
    tick();
    csb  = 1'b1;
    web  = 1'b1;
  endtask

  task automatic do_read(input logic [3:0] a);
    csb  = 1'b0;
    web  = 1'b1;
    addr = a;
    tick();
  endtask

  function automatic logic [63:0] exp12(input int i);
    case (i)
      1:       return 64'h11;
      2:       return 64'h22;
      3:       return 64'h33;
      default: return 64'h0;
    endcase
  endfunction

  initial begin
    clk = 1'b0; rst = 1'b1; csb = 1'b1; web = 1'b1;
    addr = 4'd0; din = 64'd0; wbm = 8'd0; inj = 1'b0;

    // Reset state
    tick();
    check_eq("rst_o1", o_a, 64'd0);
    check_eq("rst_ov1", 64'(ov_a), 64'd0);
    check_eq("rst_busy", 64'(busy_a), 64'd1);
    check_eq("rst_perr", 64'(perr_a), 64'd0);

    // Busy window length after reset release
    rst = 1'b0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      if (busy_c) cnt_c++;
      tick();
    end
    check_eq("busy_len_d16", 64'(cnt_a), 64'd16);
    check_eq("busy_len_d16_l2", 64'(cnt_b), 64'd16);
    check_eq("busy_len_d12", 64'(cnt_c), 64'd12);

    // All words zero after init
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i));
      check_eq("init_zero_o1", o_a, 64'd0);
      check_eq("init_zero_ov1", 64'(ov_a), 64'd1);
    end
    csb = 1'b1;
    tick();
    check_eq("ov1_pulse_end", 64'(ov_a), 64'd0);

    // Lane mask
    do_write(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(4'd3, 64'h0, 8'h0F);
    check_eq("wr_no_ov1", 64'(ov_a), 64'd0);
    check_eq("wr_o1_hold", o_a, 64'd0);
    do_read(4'd3);
    check_eq("mask_o1", o_a, 64'hFFFF_FFFF_0000_0000);
    check_eq("mask_ov1", 64'(ov_a), 64'd1);
    csb = 1'b1;
    tick();

    // Back-to-back reads, latency 1 and 2
    do_write(4'd1, 64'h11, 8'hFF);
    do_write(4'd2, 64'h22, 8'hFF);
    do_write(4'd3, 64'h33, 8'hFF);
    do_read(4'd1);
    check_eq("l2_ov_e0", 64'(ov_b), 64'd0);
    check_eq("l1_d_e0", o_a, 64'h11);
    do_read(4'd2);
    check_eq("l2_ov_e1", 64'(ov_b), 64'd1);
    check_eq("l2_d_e1", o_b, 64'h11);
    check_eq("l1_d_e1", o_a, 64'h22);
    do_read(4'd3);
    check_eq("l2_ov_e2", 64'(ov_b), 64'd1);
    check_eq("l2_d_e2", o_b, 64'h22);
    csb = 1'b1;
    tick();
    check_eq("l2_ov_e3", 64'(ov_b), 64'd1);
    check_eq("l2_d_e3", o_b, 64'h33);
    tick();
    check_eq("l2_ov_e4", 64'(ov_b), 64'd0);
    check_eq("l2_hold", o_b, 64'h33);

    // Out-of-range on DEPTH=12
    do_write(4'd13, 64'hAB, 8'hFF);
    for (int i = 0; i < 12; i++) begin
      do_read(4'(i));
      check_eq("d12_unchanged", o_c, exp12(i));
    end
    do_read(4'd12);
    check_eq("d12_oor12_o1", o_c, 64'd0);
    do_read(4'd13);
    check_eq("d12_oor_o1", o_c, 64'd0);
    check_eq("d12_oor_ov1", 64'(ov_c), 64'd1);
    check_eq("d16_a13_o1", o_a, 64'hAB);
    csb = 1'b1;
    tick();

    // Reset with a latency-2 read in flight, then reset again mid-init
    do_read(4'd1);
    check_eq("inflight_ov_e0", 64'(ov_b), 64'd0);
    check_eq("pre_rst_l1_d", o_a, 64'h11);
    rst = 1'b1;
    csb = 1'b1;
    tick();
    check_eq("rst_drop_ov", 64'(ov_b), 64'd0);
    check_eq("rst_drop_o1", o_b, 64'd0);
    rst = 1'b0;
    tick();
    check_eq("rst_drop_ov_next", 64'(ov_b), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("mid_init_busy", 64'(busy_a), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt_a = 0; cnt_c = 0; ov_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy_a) cnt_a++;
      if (busy_c) cnt_c++;
      if (ov_a) ov_cnt++;
      if (busy_a) begin
        csb  = 1'b0;
        web  = (i % 2 == 1);
        addr = 4'd0;
        din  = 64'hFFFF_FFFF_FFFF_FFFF;
        wbm  = 8'hFF;
      end else begin
        csb = 1'b1;
        web = 1'b1;
      end
      tick();
    end
    check_eq("rerun_busy_d16", 64'(cnt_a), 64'd16);
    check_eq("rerun_busy_d12", 64'(cnt_c), 64'd12);
    check_eq("busy_no_ov", 64'(ov_cnt), 64'd0);
    do_read(4'd0);
    check_eq("busy_wr_ignored", o_a, 64'd0);
    do_read(4'd1);
    check_eq("rezeroed", o_a, 64'd0);
    csb = 1'b1;
    tick();

`ifdef SRAM_SP_PARITY_EN
    inj = 1'b1;
    do_write(4'd7, 64'h0123_4567_89AB_CDEF, 8'h01);
    inj = 1'b0;
    do_read(4'd7);
    check_eq("par_inj_o1", o_a, 64'hEF);
    check_eq("par_inj_ov1", 64'(ov_a), 64'd1);
    check_eq("par_inj_perr", 64'(perr_a), 64'd1);
    csb = 1'b1;
    tick();
    check_eq("par_idle_perr", 64'(perr_a), 64'd0);
    do_write(4'd7, 64'h0123_4567_89AB_CDEF, 8'h01);
    do_read(4'd7);
    check_eq("par_clean_ov1", 64'(ov_a), 64'd1);
    check_eq("par_clean_perr", 64'(perr_a), 64'd0);
    csb = 1'b1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
